// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// All outputs come straight from flops so the serial line never glitches.
`timescale 1ns/1ps

module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic              ODD_FLIP  = (PARITY_ODD != 0);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity_en
      $error("uart_tx_cfg: PARITY_EN must be 0 or 1");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
      $error("uart_tx_cfg: PARITY_ODD must be 0 or 1");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state_reg, state_next;
  logic [BAUD_W-1:0]      baud_reg, baud_next;
  logic [3:0]             bit_reg, bit_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic                   par_reg, par_next;
  logic                   tx_reg, tx_next;
  logic                   busy_reg, busy_next;
  logic                   done_reg, done_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // tx_next always carries the level of the bit that begins on the coming edge,
  // so every bit boundary is a single registered transition.
  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    tx_next    = tx_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;

    case (state_reg)
      S_IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        baud_next = '0;
        bit_next  = '0;
        if (tx_start) begin
          shift_next = tx_data;
          par_next   = (^tx_data) ^ ODD_FLIP;
          state_next = S_START;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
        end
      end

      S_START: begin
        if (baud_reg == BAUD_LAST) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = S_DATA;
          tx_next    = shift_reg[0];
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end

      S_DATA: begin
        if (baud_reg == BAUD_LAST) begin
          baud_next = '0;
          if (bit_reg == DATA_LAST) begin
            bit_next = '0;
            if (PARITY_EN != 0) begin
              state_next = S_PARITY;
              tx_next    = par_reg;
            end else begin
              state_next = S_STOP;
              tx_next    = 1'b1;
            end
          end else begin
            bit_next   = bit_reg + 4'd1;
            tx_next    = shift_reg[1];
            shift_next = {1'b0, shift_reg[DATA_BITS-1:1]};
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end

      S_PARITY: begin
        if (baud_reg == BAUD_LAST) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = S_STOP;
          tx_next    = 1'b1;
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end

      S_STOP: begin
        tx_next = 1'b1;
        if (baud_reg == BAUD_LAST) begin
          baud_next = '0;
          if (bit_reg == STOP_LAST) begin
            bit_next   = '0;
            state_next = S_IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            bit_next = bit_reg + 4'd1;
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign tx      = tx_reg;
  assign tx_busy = busy_reg;
  assign tx_done = done_reg;

endmodule
